// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: one requester's access bus (req/write/address/wdata out, ack/rdata back).
// Modports: master = requester side (CPU or IOP), slave = arbiter side.
interface memory_arbiter_if;
  logic         req;
  logic         write;
  logic [15:31] address;
  logic [0:31]  wdata;
  logic         ack;
  logic [0:31]  rdata;
  modport master (output req, write, address, wdata, input ack, rdata);
  modport slave  (input req, write, address, wdata, output ack, rdata);
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares single-ported main memory between CPU and IOP, fixed CPU priority.
// Optional MEMARB_FAIRNESS_EN: after MAX_BURST consecutive CPU grants with the IOP waiting,
// the IOP is forced one grant.
// Ports: clock (rising edge), reset (async active-low); cpu/iop requester buses
// (memory_arbiter_if.slave, ack in the cycle after a sampled req, rdata valid with ack);
// mem_address/mem_write_en/mem_wdata/mem_rdata memory bus; owner (00 idle, 01 CPU, 10 IOP).
module memory_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic            clock,
  input  logic            reset,
  memory_arbiter_if.slave cpu,
  memory_arbiter_if.slave iop,
  output logic [15:31]    mem_address,
  output logic            mem_write_en,
  output logic [0:31]     mem_wdata,
  input  logic [0:31]     mem_rdata,
  output logic [0:1]      owner
);
  localparam logic [1:0] IDLE = 2'b00, CPU = 2'b01, IOP = 2'b10;
  logic       force_iop;
  logic [1:0] next_owner;
  logic       sel_cpu, sel_iop;
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
    $error("memory_arbiter: MAX_BURST must be 1..15");
  end
`ifdef MEMARB_FAIRNESS_EN
  localparam int SW = $clog2(MAX_BURST + 1);
  logic [SW-1:0] cpu_streak;
  assign force_iop = cpu_streak == SW'(MAX_BURST);
  // counts CPU grants won against a waiting IOP; any gap in IOP demand restarts it
  always_ff @(posedge clock or negedge reset)
    if (!reset) cpu_streak <= '0;
    else if (next_owner == CPU && iop.req) cpu_streak <= force_iop ? cpu_streak : cpu_streak + SW'(1);
    else cpu_streak <= '0;
`else
  assign force_iop = 1'b0;
`endif
  assign next_owner = (cpu.req && !(iop.req && force_iop)) ? CPU : iop.req ? IOP : IDLE;
  // async reset forces IDLE, so the whole datapath collapses to zero without a clock edge
  always_ff @(posedge clock or negedge reset)
    if (!reset) owner <= IDLE;
    else owner <= next_owner;
  assign sel_cpu = owner == CPU;
  assign sel_iop = owner == IOP;
  always_comb begin
    mem_address  = sel_cpu ? cpu.address : sel_iop ? iop.address : '0;
    mem_wdata    = sel_cpu ? cpu.wdata : sel_iop ? iop.wdata : '0;
    mem_write_en = sel_cpu ? cpu.write : sel_iop ? iop.write : 1'b0;
  end
  assign cpu.ack   = sel_cpu;
  assign iop.ack   = sel_iop;
  assign cpu.rdata = sel_cpu ? mem_rdata : '0;
  assign iop.rdata = sel_iop ? mem_rdata : '0;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed plus randomized checks of memory_arbiter against a reference model.
module tb_memory_arbiter;
  localparam int MB = 4;
`ifdef MEMARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         reset;
  logic [15:31] mem_address;
  logic         mem_write_en;
  logic [0:31]  mem_wdata;
  logic [0:31]  mem_rdata;
  logic [0:1]   owner;
  logic [0:31]  ram [256];
  logic [0:31]  ref_ram [256];
  int           errors = 0;
  int           checks = 0;
  int           m_owner = 0;
  int           m_streak = 0;
  int           prev_o;
  int           cpu_acks;
  logic [9:0]   seq;

  memory_arbiter_if cpu_bus ();
  memory_arbiter_if iop_bus ();

  memory_arbiter #(.MAX_BURST(MB)) dut (
    .clock(clk), .reset(reset), .cpu(cpu_bus), .iop(iop_bus),
    .mem_address(mem_address), .mem_write_en(mem_write_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_address[24:31]];
  always @(posedge clk) if (mem_write_en) ram[mem_address[24:31]] <= mem_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whoever was granted last cycle completes its access now; then grant by priority rules.
  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_owner  <= 0;
      m_streak <= 0;
    end else begin
      if (m_owner == 1 && cpu_bus.write) ref_ram[cpu_bus.address[24:31]] <= cpu_bus.wdata;
      if (m_owner == 2 && iop_bus.write) ref_ram[iop_bus.address[24:31]] <= iop_bus.wdata;
      if (cpu_bus.req && iop_bus.req && !(FAIR && m_streak == MB)) begin
        m_owner  <= 1;
        m_streak <= m_streak + 1;
      end else if (cpu_bus.req && !iop_bus.req) begin
        m_owner  <= 1;
        m_streak <= 0;
      end else if (iop_bus.req) begin
        m_owner  <= 2;
        m_streak <= 0;
      end else begin
        m_owner  <= 0;
        m_streak <= 0;
      end
    end

  always @(negedge clk) begin
    check("owner", owner, m_owner);
    check("cpu_ack", cpu_bus.ack, m_owner == 1);
    check("iop_ack", iop_bus.ack, m_owner == 2);
    check("mem_we", mem_write_en, m_owner == 1 ? cpu_bus.write : m_owner == 2 ? iop_bus.write : 1'b0);
    check("mem_addr", mem_address, m_owner == 1 ? cpu_bus.address : m_owner == 2 ? iop_bus.address : 17'h0);
    check("mem_wdata", mem_wdata, m_owner == 1 ? cpu_bus.wdata : m_owner == 2 ? iop_bus.wdata : 32'h0);
    check("cpu_rdata", cpu_bus.rdata, m_owner == 1 ? ref_ram[cpu_bus.address[24:31]] : 32'h0);
    check("iop_rdata", iop_bus.rdata, m_owner == 2 ? ref_ram[iop_bus.address[24:31]] : 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = {24'hC0FFEE, 8'(i)};
    ram[5] = 32'h12345678;
    ram[7] = 32'h0;
    for (int i = 0; i < 256; i++) ref_ram[i] = ram[i];
    reset = 1'b0;
    cpu_bus.req = 1'b1; cpu_bus.write = 1'b0; cpu_bus.address = 17'h5;  cpu_bus.wdata = 32'hFFFFFFFF;
    iop_bus.req = 1'b1; iop_bus.write = 1'b0; iop_bus.address = 17'h9;  iop_bus.wdata = 32'hA5A5A5A5;
    repeat (3) tick();
    check("rst_owner", owner, 2'b00);
    check("rst_cpu_ack", cpu_bus.ack, 1'b0);
    check("rst_iop_ack", iop_bus.ack, 1'b0);
    check("rst_mem_addr", mem_address, 17'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b1;
    #1;
    check("release_no_ack", cpu_bus.ack, 1'b0);
    tick();
    check("first_ack_cpu", cpu_bus.ack, 1'b1);
    cpu_bus.req = 1'b0;
    iop_bus.req = 1'b0;
    tick();
    // CPU read of preloaded word
    cpu_bus.req = 1'b1; cpu_bus.address = 17'h5;
    tick();
    check("rd_ack", cpu_bus.ack, 1'b1);
    check("rd_data", cpu_bus.rdata, 32'h12345678);
    check("rd_we", mem_write_en, 1'b0);
    cpu_bus.req = 1'b0;
    tick();
    check("rd_ack_one_cycle", cpu_bus.ack, 1'b0);
    // IOP write then CPU read-back
    iop_bus.req = 1'b1; iop_bus.write = 1'b1; iop_bus.address = 17'h10; iop_bus.wdata = 32'hDEADBEEF;
    tick();
    check("iop_wr_ack", iop_bus.ack, 1'b1);
    check("iop_wr_we", mem_write_en, 1'b1);
    iop_bus.req = 1'b0;
    tick();
    check("iop_wr_ack_one_cycle", iop_bus.ack, 1'b0);
    iop_bus.write = 1'b0;
    cpu_bus.req = 1'b1; cpu_bus.address = 17'h10;
    tick();
    check("readback", cpu_bus.rdata, 32'hDEADBEEF);
    cpu_bus.req = 1'b0;
    tick();
    // continuous contention for 10 edges
    cpu_bus.req = 1'b1; cpu_bus.address = 17'h1;
    iop_bus.req = 1'b1; iop_bus.address = 17'h2;
    seq = '0;
    cpu_acks = 0;
    repeat (10) begin
      tick();
      seq = {seq[8:0], iop_bus.ack};
      cpu_acks += int'(cpu_bus.ack);
    end
    check("contention_iop_seq", seq, FAIR ? 10'b0000100001 : 10'b0);
    check("contention_cpu_count", cpu_acks, FAIR ? 8 : 10);
    cpu_bus.req = 1'b0;
    iop_bus.req = 1'b0;
    repeat (2) tick();
    // back-to-back CPU reads
    cpu_bus.req = 1'b1; cpu_bus.address = 17'h1;
    tick();
    check("b2b_1", cpu_bus.rdata, 32'hC0FFEE01);
    cpu_bus.address = 17'h2;
    tick();
    check("b2b_2", cpu_bus.rdata, 32'hC0FFEE02);
    cpu_bus.address = 17'h3;
    tick();
    check("b2b_3", cpu_bus.rdata, 32'hC0FFEE03);
    cpu_bus.req = 1'b0;
    tick();
    // reset asserted mid-way through a write ack cycle
    cpu_bus.req = 1'b1; cpu_bus.write = 1'b1; cpu_bus.address = 17'h7; cpu_bus.wdata = 32'hFFFFFFFF;
    tick();
    check("abort_we_before", mem_write_en, 1'b1);
    cpu_bus.req = 1'b0;
    #3 reset = 1'b0;
    #1;
    check("abort_we", mem_write_en, 1'b0);
    check("abort_ack", cpu_bus.ack, 1'b0);
    tick();
    check("abort_ram7", ram[7], 32'h0);
    cpu_bus.write = 1'b0;
    reset = 1'b1;
    tick();
    // randomized traffic obeying the requester protocol
    prev_o = m_owner;
    repeat (400) begin
      tick();
      if (prev_o == 1 && cpu_bus.req) begin
        cpu_bus.write = 1'($urandom_range(0, 1)); cpu_bus.address = 17'($urandom_range(0, 15)); cpu_bus.wdata = $urandom;
      end
      if (m_owner == 1) cpu_bus.req = 1'($urandom_range(0, 1));
      else if (!cpu_bus.req && $urandom_range(0, 2) == 0) begin
        cpu_bus.req = 1'b1;
        cpu_bus.write = 1'($urandom_range(0, 1)); cpu_bus.address = 17'($urandom_range(0, 15)); cpu_bus.wdata = $urandom;
      end
      if (prev_o == 2 && iop_bus.req) begin
        iop_bus.write = 1'($urandom_range(0, 1)); iop_bus.address = 17'($urandom_range(0, 15)); iop_bus.wdata = $urandom;
      end
      if (m_owner == 2) iop_bus.req = 1'($urandom_range(0, 1));
      else if (!iop_bus.req && $urandom_range(0, 1) == 0) begin
        iop_bus.req = 1'b1;
        iop_bus.write = 1'($urandom_range(0, 1)); iop_bus.address = 17'($urandom_range(0, 15)); iop_bus.wdata = $urandom;
      end
      prev_o = m_owner;
    end
    cpu_bus.req = 1'b0;
    iop_bus.req = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) check("final_ram", ram[i], ref_ram[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
